// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned JIDX_W = 26;
  localparam int unsigned CNT_W  = 32;

  localparam int unsigned      PC_STEP  = 4;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_LOAD   = 2'd1,
    IFID_BUBBLE = 2'd2
  } ifid_op_e;

endpackage

// File: rtl/fetch_pipe_ifid_reg.sv
// IF/ID pipeline register: load a fetched instruction, hold it, or write a NOP bubble.
module ifid_reg
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  ifid_op_e          op,
  input  logic [INST_W-1:0] inst_in,
  input  logic [XLEN-1:0]   pc4_in,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   pc4,
  output logic              valid
);

  logic [INST_W-1:0] inst_q, inst_d;
  logic [XLEN-1:0]   pc4_q, pc4_d;
  logic              valid_q, valid_d;

  always_comb begin
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    unique case (op)
      IFID_LOAD: begin
        inst_d  = inst_in;
        pc4_d   = pc4_in;
        valid_d = 1'b1;
      end
      IFID_BUBBLE: begin
        inst_d  = NOP_INST;
        pc4_d   = '0;
        valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q  <= NOP_INST;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign inst  = inst_q;
  assign pc4   = pc4_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_pipe.sv
// Instruction-fetch stage: PC, next-PC selection, BOOT/RUN/HALT control and IF/ID register.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_pipe
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RST,
  output logic [XLEN-1:0]   ImemAddr,
  input  logic [INST_W-1:0] ImemData,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              BranchTaken,
  input  logic [XLEN-1:0]   BranchTarget,
  input  logic              Jump,
  input  logic [JIDX_W-1:0] JumpIndex,
  input  logic [XLEN-1:0]   JumpPC4,
  input  logic              Halt,
  input  logic              Resume,
  output logic [INST_W-1:0] IFID_Inst,
  output logic [XLEN-1:0]   IFID_PC4,
  output logic              IFID_Valid,
  output logic              Halted,
  output logic [CNT_W-1:0]  FetchCount,
  output logic [CNT_W-1:0]  BubbleCount
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            halted_q, halted_d;
  ifid_op_e        ifid_op;
  logic            redirect;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] jump_target;

  assign redirect    = BranchTaken | Jump;
  assign pc_plus4    = pc_q + XLEN'(PC_STEP);
  assign jump_target = XLEN'({JumpPC4[31:28], JumpIndex, 2'b00});

  always_ff @(posedge CLK) begin
    if (RST) state_q <= BOOT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (Halt && !redirect) state_d = HALT;
      HALT:    if (Resume) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // IF/ID control; a redirect squashes the wrong-path fetch even under Stall.
  always_comb begin
    ifid_op  = IFID_LOAD;
    halted_d = (state_d == HALT);
    if (RST || state_q == BOOT)  ifid_op = IFID_BUBBLE;
    else if (redirect)           ifid_op = IFID_BUBBLE;
    else if (Flush)              ifid_op = IFID_BUBBLE;
    else if (Stall)              ifid_op = IFID_HOLD;
    else if (state_q == HALT)    ifid_op = IFID_BUBBLE;
  end

  // PC holds during BOOT so RESET_PC is the first address loaded into IF/ID.
  always_comb begin
    pc_d = pc_plus4;
    if (BranchTaken)                    pc_d = BranchTarget;
    else if (Jump)                      pc_d = jump_target;
    else if (Stall || state_q != RUN)   pc_d = pc_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  ifid_reg #(.XLEN(XLEN)) u_ifid (
    .clk     (CLK),
    .rst     (RST),
    .op      (ifid_op),
    .inst_in (ImemData),
    .pc4_in  (pc_plus4),
    .inst    (IFID_Inst),
    .pc4     (IFID_PC4),
    .valid   (IFID_Valid)
  );

  assign ImemAddr = pc_q;
  assign Halted   = halted_q;

`ifdef FETCH_PERF_EN
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating counters; hold cycles count as neither fetch nor bubble.
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (ifid_op == IFID_LOAD && fetch_cnt_q != '1)
      fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
    if (ifid_op == IFID_BUBBLE && bubble_cnt_q != '1)
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign FetchCount  = fetch_cnt_q;
  assign BubbleCount = bubble_cnt_q;
`else
  assign FetchCount  = '0;
  assign BubbleCount = '0;
`endif

endmodule

// File: tb/tb_fetch_pipe.sv
// Self-checking bench for fetch_pipe: directed scenarios plus randomized traffic against a cycle model.
module tb_fetch_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall, flush, branch_taken, jump, halt, resume;
  logic [31:0] branch_target, jump_pc4;
  logic [25:0] jump_index;
  logic [31:0] ifid_inst, ifid_pc4;
  logic        ifid_valid, halted;
  logic [31:0] fetch_count, bubble_count;

  int checks = 0;
  int errors = 0;

  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  // Reference model state
  int          m_mode;
  logic [31:0] m_pc, m_inst, m_pc4;
  logic        m_valid, m_halted;
  logic [31:0] m_fc, m_bc;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_data = imem(imem_addr);

  fetch_pipe #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .CLK          (clk),
    .RST          (rst),
    .ImemAddr     (imem_addr),
    .ImemData     (imem_data),
    .Stall        (stall),
    .Flush        (flush),
    .BranchTaken  (branch_taken),
    .BranchTarget (branch_target),
    .Jump         (jump),
    .JumpIndex    (jump_index),
    .JumpPC4      (jump_pc4),
    .Halt         (halt),
    .Resume       (resume),
    .IFID_Inst    (ifid_inst),
    .IFID_PC4     (ifid_pc4),
    .IFID_Valid   (ifid_valid),
    .Halted       (halted),
    .FetchCount   (fetch_count),
    .BubbleCount  (bubble_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    rst = 1'b0; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    halt = 1'b0; resume = 1'b0; branch_target = '0; jump_pc4 = '0; jump_index = '0;
  endtask

  task automatic bubble_model(input logic count);
    m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    if (count) m_bc = m_bc + 32'd1;
  endtask

  // Apply one clock edge to the model using the current inputs.
  task automatic model_edge();
    logic [31:0] old_pc;
    logic        redir;
    old_pc = m_pc;
    redir  = branch_taken | jump;
    if (rst) begin
      m_pc = 32'h0; m_mode = M_BOOT; m_halted = 1'b0;
      bubble_model(1'b0); m_fc = 0; m_bc = 0;
    end else begin
      if (m_mode == M_BOOT || redir || flush) bubble_model(1'b1);
      else if (stall) ;
      else if (m_mode == M_HALT) bubble_model(1'b1);
      else begin
        m_inst = imem(old_pc); m_pc4 = old_pc + 32'd4; m_valid = 1'b1;
        m_fc = m_fc + 32'd1;
      end
      if (branch_taken)                   m_pc = branch_target;
      else if (jump)                      m_pc = {jump_pc4[31:28], jump_index, 2'b00};
      else if (!stall && m_mode == M_RUN) m_pc = old_pc + 32'd4;
      if (m_mode == M_BOOT)                          m_mode = M_RUN;
      else if (m_mode == M_RUN && halt && !redir)    m_mode = M_HALT;
      else if (m_mode == M_HALT && resume)           m_mode = M_RUN;
      m_halted = (m_mode == M_HALT);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("addr",   imem_addr, m_pc);
    chk("inst",   ifid_inst, m_inst);
    chk("pc4",    ifid_pc4,  m_pc4);
    chk("valid",  {31'b0, ifid_valid}, {31'b0, m_valid});
    chk("halted", {31'b0, halted},     {31'b0, m_halted});
`ifdef FETCH_PERF_EN
    chk("fcount", fetch_count,  m_fc);
    chk("bcount", bubble_count, m_bc);
`else
    chk("fcount", fetch_count,  32'h0);
    chk("bcount", bubble_count, 32'h0);
`endif
  endtask

  initial begin
    m_mode = M_BOOT; m_pc = 0; m_inst = 0; m_pc4 = 0; m_valid = 0; m_halted = 0;
    m_fc = 0; m_bc = 0;
    clr();

    // Reset state
    rst = 1'b1; tick(); tick();
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_valid", {31'b0, ifid_valid}, 32'h0);
    chk("rst_halt",  {31'b0, halted}, 32'h0);
    rst = 1'b0;

    // BOOT bubble then sequential fetch
    tick(); chk("boot_valid", {31'b0, ifid_valid}, 32'h0);
    tick(); chk("seq_pc4_4",  ifid_pc4, 32'h4);
    tick(); chk("seq_pc4_8",  ifid_pc4, 32'h8);
    tick(); chk("seq_pc4_c",  ifid_pc4, 32'hC);
    tick(); chk("pc_at_10",   imem_addr, 32'h10);

    // Stall three cycles at PC=0x10
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_addr", imem_addr, 32'h10);
      chk("stall_pc4",  ifid_pc4,  32'h10);
    end
    stall = 1'b0;
    tick(); chk("unstall_14", ifid_pc4, 32'h14);
    tick(); chk("unstall_18", ifid_pc4, 32'h18);

    // Jump
    jump = 1'b1; jump_pc4 = 32'h1000_0008; jump_index = 26'h40;
    tick(); clr();
    chk("jump_addr",   imem_addr, 32'h1000_0100);
    chk("jump_bubble", {31'b0, ifid_valid}, 32'h0);
    tick(); chk("jump_pc4", ifid_pc4, 32'h1000_0104);
    chk("jump_valid", {31'b0, ifid_valid}, 32'h1);

    // Branch beats Jump and Stall
    branch_taken = 1'b1; branch_target = 32'h80; jump = 1'b1; stall = 1'b1;
    jump_pc4 = 32'h2000_0000; jump_index = 26'h123;
    tick(); clr();
    chk("br_addr",   imem_addr, 32'h80);
    chk("br_bubble", {31'b0, ifid_valid}, 32'h0);

    // Halt so the held PC is 0x20
    branch_taken = 1'b1; branch_target = 32'h1C; tick(); clr();
    halt = 1'b1; tick(); clr();
    chk("halt_flag", {31'b0, halted}, 32'h1);
    chk("halt_addr", imem_addr, 32'h20);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("halt_hold",   imem_addr, 32'h20);
      chk("halt_bubble", {31'b0, ifid_valid}, 32'h0);
    end
    halt = 1'b1; resume = 1'b1; tick(); clr();
    chk("resume_flag", {31'b0, halted}, 32'h0);
    tick(); chk("resume_pc4", ifid_pc4, 32'h24);

    // PC wraps at 2^32
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC; tick(); clr();
    tick();
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc4",  ifid_pc4,  32'h0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst           = ($urandom_range(49) == 0);
      branch_taken  = ($urandom_range(7) == 0);
      jump          = ($urandom_range(7) == 0);
      stall         = ($urandom_range(4) == 0);
      flush         = ($urandom_range(7) == 0);
      halt          = ($urandom_range(9) == 0);
      resume        = ($urandom_range(3) == 0);
      branch_target = $urandom;
      jump_pc4      = $urandom;
      jump_index    = 26'($urandom);
      tick();
    end
    clr();

    // Counters: 10 valid fetches, 2 jumps, plus the BOOT bubble
    rst = 1'b1; tick(); rst = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) tick();
    jump = 1'b1; jump_pc4 = 32'h0; jump_index = 26'h100; tick(); clr();
    for (int i = 0; i < 5; i++) tick();
    jump = 1'b1; jump_pc4 = 32'h0; jump_index = 26'h200; tick(); clr();
`ifdef FETCH_PERF_EN
    chk("perf_fetch",  fetch_count,  32'd10);
    chk("perf_bubble", bubble_count, 32'd3);
`else
    chk("perf_fetch",  fetch_count,  32'd0);
    chk("perf_bubble", bubble_count, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
